simon_engine: RTL

SIMON_ENGINE -- requirements
Module: simon_engine

---
 rtl/simon_engine.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/simon_engine.sv
// Simon memory game: LFSR-generated colour sequence, timed lamp playback,
// and edge-detected player input with an idle timeout.
module simon_engine #(
    parameter int NUM_COLOURS = 4,
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYC    = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64,
    localparam int COL_W      = $clog2(NUM_COLOURS),
    localparam int SC_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             seed,
    input  logic [NUM_COLOURS-1:0] btn,
    output logic [NUM_COLOURS-1:0] led,
    output logic [2:0]             state,
    output logic [SC_W-1:0]        score,
    output logic                   win,
    output logic                   lose
);

    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int PH_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GEN      = 3'd1;
    localparam logic [2:0] ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] ST_SHOW_OFF = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;
    localparam logic [2:0] ST_WIN      = 3'd6;
    localparam logic [2:0] ST_LOSE     = 3'd7;

    logic [2:0]             state_reg, state_next;
    logic [7:0]             lfsr_reg, lfsr_next, lfsr_step;
    logic [IDX_W-1:0]       wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [SC_W-1:0]        len_reg, len_next;
    logic [SC_W-1:0]        score_reg, score_next;
    logic [PH_W-1:0]        ph_reg, ph_next;
    logic [TO_W-1:0]        to_reg, to_next;
    logic                   pend_reg, pend_next;
    logic [NUM_COLOURS-1:0] btn_prev_reg;
    logic                   win_reg, lose_reg;
    logic                   mem_we;
    logic [COL_W-1:0]       mem [MAX_LEN];
    logic [COL_W-1:0]       rd_data_reg;
    logic [NUM_COLOURS-1:0] expect_oh;
    logic                   press;
    logic                   idx_last;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting towards the LSB
    assign lfsr_step = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
    assign press     = (btn != '0) && (btn_prev_reg == '0);
    assign idx_last  = ((SC_W'(idx_reg) + SC_W'(1)) == len_reg);

    // rd_data_reg always holds mem[idx_reg]; the read address is idx_next
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLOURS; gi++) begin : g_oh
            assign expect_oh[gi] = (rd_data_reg == COL_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        lfsr_next   = lfsr_reg;
        wr_idx_next = wr_idx_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        score_next  = score_reg;
        ph_next     = ph_reg;
        to_next     = to_reg;
        pend_next   = pend_reg;
        mem_we      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    lfsr_next   = (seed == 8'h00) ? 8'h01 : seed;
                    score_next  = '0;
                    wr_idx_next = '0;
                    idx_next    = '0;
                    len_next    = '0;
                    ph_next     = '0;
                    to_next     = '0;
                    pend_next   = 1'b0;
                    state_next  = ST_GEN;
                end
            end
            ST_GEN: begin
                lfsr_next = lfsr_step;
                mem_we    = 1'b1;
                if (wr_idx_reg == IDX_W'(MAX_LEN - 1)) begin
                    len_next   = SC_W'(1);
                    idx_next   = '0;
                    ph_next    = '0;
                    state_next = ST_SHOW_ON;
                end else begin
                    wr_idx_next = wr_idx_reg + IDX_W'(1);
                end
            end
            ST_SHOW_ON: begin
                if (ph_reg == PH_W'(SHOW_CYC - 1)) begin
                    ph_next    = '0;
                    state_next = ST_SHOW_OFF;
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end
            ST_SHOW_OFF: begin
                if (ph_reg == PH_W'(GAP_CYC - 1)) begin
                    ph_next = '0;
                    if (!idx_last) begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_SHOW_ON;
                    end else begin
                        idx_next   = '0;
                        to_next    = '0;
                        state_next = ST_INPUT;
                    end
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end
            ST_INPUT: begin
                // a press on the final timeout cycle still wins over the timeout
                if (press) begin
                    if (btn != expect_oh) begin
                        state_next = ST_LOSE;
                    end else if (!idx_last) begin
                        idx_next   = idx_reg + IDX_W'(1);
                        to_next    = '0;
                        state_next = ST_RELEASE;
                    end else begin
                        score_next = (score_reg == SC_W'(MAX_LEN)) ? score_reg
                                                                   : score_reg + SC_W'(1);
                        to_next    = '0;
                        if (len_reg == SC_W'(MAX_LEN)) begin
                            state_next = ST_WIN;
                        end else begin
                            len_next   = len_reg + SC_W'(1);
                            idx_next   = '0;
                            pend_next  = 1'b1;
                            state_next = ST_RELEASE;
                        end
                    end
                end else if (to_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_next = ST_LOSE;
                end else begin
                    to_next = to_reg + TO_W'(1);
                end
            end
            ST_RELEASE: begin
                if (btn == '0) begin
                    ph_next    = '0;
                    pend_next  = 1'b0;
                    state_next = pend_reg ? ST_SHOW_ON : ST_INPUT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= 8'h01;
            wr_idx_reg   <= '0;
            idx_reg      <= '0;
            len_reg      <= '0;
            score_reg    <= '0;
            ph_reg       <= '0;
            to_reg       <= '0;
            pend_reg     <= 1'b0;
            btn_prev_reg <= '0;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            wr_idx_reg   <= wr_idx_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            score_reg    <= score_next;
            ph_reg       <= ph_next;
            to_reg       <= to_next;
            pend_reg     <= pend_next;
            btn_prev_reg <= btn;
            win_reg      <= (state_next == ST_WIN);
            lose_reg     <= (state_next == ST_LOSE);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx_reg] <= lfsr_step[COL_W-1:0];
        end
        rd_data_reg <= mem[idx_next];
    end

    always_comb begin
        led = '0;
        case (state_reg)
            ST_SHOW_ON, ST_LOSE: led = expect_oh;
            ST_WIN:              led = '1;
            default:             led = '0;
        endcase
    end

    assign state = state_reg;
    assign score = score_reg;
    assign win   = win_reg;
    assign lose  = lose_reg;

endmodule
